// File: rtl/sram_dp_param_if.sv
// Port bundle for the dual-port SRAM model.
//   master : requester side, drives cen/wen/addr/wmsk/wdata of both ports,
//            receives rdata_a/rdata_b and the collision flag.
//   slave  : memory side.
// wmsk bits: 1 = keep the stored bit, 0 = take the wdata bit.
interface sram_dp_param_if #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
);
    logic                  cen_a, wen_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] wmsk_a, wdata_a, rdata_a;
    logic                  cen_b, wen_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] wmsk_b, wdata_b, rdata_b;
    logic                  coll;

    modport master (
        output cen_a, wen_a, addr_a, wmsk_a, wdata_a,
        output cen_b, wen_b, addr_b, wmsk_b, wdata_b,
        input  rdata_a, rdata_b, coll
    );

    modport slave (
        input  cen_a, wen_a, addr_a, wmsk_a, wdata_a,
        input  cen_b, wen_b, addr_b, wmsk_b, wdata_b,
        output rdata_a, rdata_b, coll
    );
endinterface

// File: rtl/sram_dp_param.sv
// Parametrised single-clock true dual-port synchronous SRAM model.
//   clk   : shared clock for both ports
//   rst_n : async active-low reset; clears read pipelines and coll, not the array
//   bus   : slave modport carrying both ports' controls, data and coll
// Read latency 1 or 2, same-port read-during-write selectable by RDW_MODE
// (0 old data, 1 merged new data, 2 rdata holds). Cross-port reads of a word
// being written on the same edge return the pre-write word. On a same-address
// dual write the winner (COLL_PRIO_A) is stored and coll pulses next cycle.
module sram_dp_param #(
    parameter int DATA_WIDTH  = 18,
    parameter int ADDR_WIDTH  = 10,
    parameter int READ_LAT    = 1,
    parameter int RDW_MODE    = 0,
    parameter int COLL_PRIO_A = 1,
    parameter logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0] INIT =
        {(DATA_WIDTH*(2**ADDR_WIDTH)){1'bx}}
) (
    input  logic           clk,
    input  logic           rst_n,
    sram_dp_param_if.slave bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int NP    = 2;  // port 0 = A, port 1 = B

    logic [NP-1:0]                 cen, wen, acc, wr, wr_eff;
    logic [NP-1:0][ADDR_WIDTH-1:0] addr;
    logic [NP-1:0][DATA_WIDTH-1:0] wmsk, wdata, old, merged, rdata;
    logic                          same_ww;
    logic                          coll_q;

    // Flat storage so INIT maps word-for-word onto the array.
    logic [DEPTH*DATA_WIDTH-1:0] mem = INIT;

    assign cen   = {bus.cen_b,   bus.cen_a};
    assign wen   = {bus.wen_b,   bus.wen_a};
    assign addr  = {bus.addr_b,  bus.addr_a};
    assign wmsk  = {bus.wmsk_b,  bus.wmsk_a};
    assign wdata = {bus.wdata_b, bus.wdata_a};

    assign bus.rdata_a = rdata[0];
    assign bus.rdata_b = rdata[1];
    assign bus.coll    = coll_q;

    // Both merges use the pre-edge word, so dropping the loser's enable is
    // enough to discard its write entirely.
    assign same_ww   = wr[0] & wr[1] & (addr[0] == addr[1]);
    assign wr_eff[0] = wr[0] & ~(same_ww & (COLL_PRIO_A == 0));
    assign wr_eff[1] = wr[1] & ~(same_ww & (COLL_PRIO_A != 0));

    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (wr_eff[p])
                mem[int'(addr[p])*DATA_WIDTH +: DATA_WIDTH] <= merged[p];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) coll_q <= 1'b0;
        else        coll_q <= same_ww;
    end

    for (genvar p = 0; p < NP; p++) begin : g_port
        logic                  ld1;
        logic [DATA_WIDTH-1:0] s1_data;
        logic [DATA_WIDTH-1:0] rd_q;

        // No array access at all while reset is held.
        assign acc[p]    = rst_n & ~cen[p];
        assign wr[p]     = acc[p] & ~wen[p];
        assign old[p]    = mem[int'(addr[p])*DATA_WIDTH +: DATA_WIDTH];
        assign merged[p] = (old[p] & wmsk[p]) | (wdata[p] & ~wmsk[p]);

        // NO_CHANGE writes never raise the pipeline enable.
        assign ld1     = acc[p] & ~(wr[p] & (RDW_MODE == 2));
        assign s1_data = (wr[p] && RDW_MODE == 1) ? merged[p] : old[p];
        assign rdata[p] = rd_q;

        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s1_q;
            logic                  vld_pipe;  // stage 1 loaded on the last edge

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_q     <= '0;
                    vld_pipe <= 1'b0;
                    rd_q     <= '0;
                end else begin
                    vld_pipe <= ld1;
                    if (ld1)      s1_q <= s1_data;
                    if (vld_pipe) rd_q <= s1_q;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   rd_q <= '0;
                else if (ld1) rd_q <= s1_data;
            end
        end
    end
endmodule

// File: tb/tb_sram_dp_param.sv
// Directed bench for sram_dp_param. Five instances share one stimulus stream:
//   0 RF : lat 1, read-first,  A wins      1 WF : lat 1, write-first
//   2 NC : lat 1, no-change                3 PB : lat 1, read-first, B wins
//   4 L2 : lat 2, read-first, A wins
module tb_sram_dp_param;
    localparam int DW = 18;
    localparam int AW = 4;
    localparam int NI = 5;
    localparam int RF = 0, WF = 1, NC = 2, PB = 3, L2 = 4;

    // words 1,2,4,5,7 preset; the rest zero
    localparam logic [DW*(2**AW)-1:0] INIT_V = {
        {8{18'h00000}}, 18'h00001, 18'h00000, 18'h2AAAA, 18'h0ABCD,
        18'h00000, 18'h00222, 18'h00111, 18'h00000};

    logic clk = 1'b0;
    logic rst_n;
    logic cen_a, wen_a, cen_b, wen_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wmsk_a, wdata_a, wmsk_b, wdata_b;

    logic [NI-1:0][DW-1:0] ra, rb;
    logic [NI-1:0]         col;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sram_dp_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

        assign bus.cen_a   = cen_a;
        assign bus.wen_a   = wen_a;
        assign bus.addr_a  = addr_a;
        assign bus.wmsk_a  = wmsk_a;
        assign bus.wdata_a = wdata_a;
        assign bus.cen_b   = cen_b;
        assign bus.wen_b   = wen_b;
        assign bus.addr_b  = addr_b;
        assign bus.wmsk_b  = wmsk_b;
        assign bus.wdata_b = wdata_b;
        assign ra[g]  = bus.rdata_a;
        assign rb[g]  = bus.rdata_b;
        assign col[g] = bus.coll;

        sram_dp_param #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .READ_LAT   (g == 4 ? 2 : 1),
            .RDW_MODE   (g == 1 ? 1 : (g == 2 ? 2 : 0)),
            .COLL_PRIO_A(g == 3 ? 0 : 1),
            .INIT       (INIT_V)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cen_a = 1'b1; wen_a = 1'b1; addr_a = '0; wmsk_a = '1; wdata_a = '0;
        cen_b = 1'b1; wen_b = 1'b1; addr_b = '0; wmsk_b = '1; wdata_b = '0;
    endtask

    task automatic rd_a(input logic [AW-1:0] a);
        cen_a = 1'b0; wen_a = 1'b1; addr_a = a;
    endtask

    task automatic rd_b(input logic [AW-1:0] a);
        cen_b = 1'b0; wen_b = 1'b1; addr_b = a;
    endtask

    task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        cen_a = 1'b0; wen_a = 1'b0; addr_a = a; wdata_a = d; wmsk_a = m;
    endtask

    task automatic wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        cen_b = 1'b0; wen_b = 1'b0; addr_b = a; wdata_b = d; wmsk_b = m;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ra[RF] !== 18'h0) begin errors++; $display("FAIL reset_rdata_a: got %h want %h", ra[RF], 18'h0); end
        checks++; if (col[RF] !== 1'b0) begin errors++; $display("FAIL reset_coll: got %b want 0", col[RF]); end
        rd_a(4'd5);
        cyc();
        checks++; if (ra[RF] !== 18'h0) begin errors++; $display("FAIL reset_held_read: got %h want %h", ra[RF], 18'h0); end
        rst_n = 1'b1;
        cyc();
        checks++; if (ra[RF] !== 18'h2AAAA) begin errors++; $display("FAIL first_read_a5: got %h want %h", ra[RF], 18'h2AAAA); end
        checks++; if (ra[L2] !== 18'h0) begin errors++; $display("FAIL lat2_first_edge: got %h want %h", ra[L2], 18'h0); end
        idle();
        cyc();
        checks++; if (ra[L2] !== 18'h2AAAA) begin errors++; $display("FAIL lat2_second_edge: got %h want %h", ra[L2], 18'h2AAAA); end
    endtask

    task automatic test_write_mask();
        idle();
        wr_a(4'd3, 18'h3FFFF, 18'h000FF);
        rd_b(4'd3);
        cyc();
        checks++; if (rb[RF] !== 18'h00000) begin errors++; $display("FAIL cross_port_old: got %h want %h", rb[RF], 18'h00000); end
        checks++; if (ra[RF] !== 18'h00000) begin errors++; $display("FAIL mask_rf_rdata: got %h want %h", ra[RF], 18'h00000); end
        checks++; if (ra[WF] !== 18'h3FF00) begin errors++; $display("FAIL mask_wf_rdata: got %h want %h", ra[WF], 18'h3FF00); end
        idle();
        rd_a(4'd3);
        cyc();
        checks++; if (ra[RF] !== 18'h3FF00) begin errors++; $display("FAIL mask_readback: got %h want %h", ra[RF], 18'h3FF00); end
    endtask

    task automatic test_rdw();
        idle();
        rd_a(4'd4);
        cyc();
        checks++; if (ra[NC] !== 18'h0ABCD) begin errors++; $display("FAIL rdw_prior: got %h want %h", ra[NC], 18'h0ABCD); end
        wr_a(4'd7, 18'h12345, 18'h00000);
        cyc();
        checks++; if (ra[RF] !== 18'h00001) begin errors++; $display("FAIL rdw_read_first: got %h want %h", ra[RF], 18'h00001); end
        checks++; if (ra[WF] !== 18'h12345) begin errors++; $display("FAIL rdw_write_first: got %h want %h", ra[WF], 18'h12345); end
        checks++; if (ra[NC] !== 18'h0ABCD) begin errors++; $display("FAIL rdw_no_change: got %h want %h", ra[NC], 18'h0ABCD); end
        rd_a(4'd7);
        cyc();
        checks++; if (ra[NC] !== 18'h12345) begin errors++; $display("FAIL rdw_nc_stored: got %h want %h", ra[NC], 18'h12345); end
    endtask

    task automatic test_collision();
        idle();
        wr_a(4'd9, 18'h11111, 18'h00000);
        wr_b(4'd9, 18'h22222, 18'h00000);
        cyc();
        checks++; if (col[RF] !== 1'b1) begin errors++; $display("FAIL coll_set_prio_a: got %b want 1", col[RF]); end
        checks++; if (col[PB] !== 1'b1) begin errors++; $display("FAIL coll_set_prio_b: got %b want 1", col[PB]); end
        idle();
        rd_a(4'd9);
        rd_b(4'd9);
        cyc();
        checks++; if (col[RF] !== 1'b0) begin errors++; $display("FAIL coll_one_cycle: got %b want 0", col[RF]); end
        checks++; if (ra[RF] !== 18'h11111) begin errors++; $display("FAIL coll_a_wins: got %h want %h", ra[RF], 18'h11111); end
        checks++; if (ra[PB] !== 18'h22222) begin errors++; $display("FAIL coll_b_wins: got %h want %h", ra[PB], 18'h22222); end
        checks++; if (rb[PB] !== 18'h22222) begin errors++; $display("FAIL coll_b_wins_portb: got %h want %h", rb[PB], 18'h22222); end
        idle();
        wr_a(4'd10, 18'h00001, 18'h00000);
        wr_b(4'd11, 18'h00002, 18'h00000);
        cyc();
        checks++; if (col[RF] !== 1'b0) begin errors++; $display("FAIL coll_diff_addr: got %b want 0", col[RF]); end
        idle();
        rd_a(4'd10);
        rd_b(4'd11);
        cyc();
        checks++; if (ra[RF] !== 18'h00001) begin errors++; $display("FAIL dual_write_a: got %h want %h", ra[RF], 18'h00001); end
        checks++; if (rb[RF] !== 18'h00002) begin errors++; $display("FAIL dual_write_b: got %h want %h", rb[RF], 18'h00002); end
    endtask

    task automatic test_lat2();
        idle();
        rd_a(4'd1);
        cyc();
        checks++; if (ra[RF] !== 18'h00111) begin errors++; $display("FAIL lat1_word1: got %h want %h", ra[RF], 18'h00111); end
        rd_a(4'd2);
        cyc();
        checks++; if (ra[L2] !== 18'h00111) begin errors++; $display("FAIL lat2_word1: got %h want %h", ra[L2], 18'h00111); end
        rd_a(4'd3);
        cyc();
        checks++; if (ra[L2] !== 18'h00222) begin errors++; $display("FAIL lat2_word2: got %h want %h", ra[L2], 18'h00222); end
        idle();
        cyc();
        checks++; if (ra[L2] !== 18'h3FF00) begin errors++; $display("FAIL lat2_word3: got %h want %h", ra[L2], 18'h3FF00); end
        cyc();
        checks++; if (ra[L2] !== 18'h3FF00) begin errors++; $display("FAIL lat2_hold: got %h want %h", ra[L2], 18'h3FF00); end
    endtask

    task automatic test_reset_midstream();
        idle();
        rd_a(4'd5);
        cyc();
        rd_a(4'd1);
        cyc();
        checks++; if (ra[L2] !== 18'h2AAAA) begin errors++; $display("FAIL mid_pre_reset: got %h want %h", ra[L2], 18'h2AAAA); end
        idle();
        rst_n = 1'b0;
        #1;
        checks++; if (ra[L2] !== 18'h0) begin errors++; $display("FAIL mid_async_clear_l2: got %h want %h", ra[L2], 18'h0); end
        checks++; if (ra[RF] !== 18'h0) begin errors++; $display("FAIL mid_async_clear_rf: got %h want %h", ra[RF], 18'h0); end
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++; if (ra[L2] !== 18'h0) begin errors++; $display("FAIL mid_no_stale_1: got %h want %h", ra[L2], 18'h0); end
        cyc();
        checks++; if (ra[L2] !== 18'h0) begin errors++; $display("FAIL mid_no_stale_2: got %h want %h", ra[L2], 18'h0); end
        rd_a(4'd2);
        cyc();
        checks++; if (ra[L2] !== 18'h0) begin errors++; $display("FAIL mid_new_read_wait: got %h want %h", ra[L2], 18'h0); end
        idle();
        cyc();
        checks++; if (ra[L2] !== 18'h00222) begin errors++; $display("FAIL mid_new_read: got %h want %h", ra[L2], 18'h00222); end
    endtask

    initial begin
        test_reset();
        test_write_mask();
        test_rdw();
        test_collision();
        test_lat2();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
